fetch_unit: RTL and testbench

- Instruction-fetch stage of the pipelined processor; it is the requester side of the instruction memory.
- Owns the PC and drives the word address to the asynchronous-read instruction memory.
- Captures each returned instruction with its PC into a small prefetch buffer.
- Presents entries to decode over a valid/ready handshake; supports redirect (branch/jump), stall via backpressure, and halt detection.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/fetch_unit.sv | 143 ++++++++++++++
 tb/tb_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage: FSM states, buffer entry layout
// and the fixed instruction size in bytes.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 32;
  localparam int FETCH_INSTR_W = 32;
  localparam int INSTR_BYTES   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO with flush. A push is accepted when full
// only if a pop happens at the same edge; flush overrides push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  entry_t           wdata_i,
  output entry_t           rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t           mem_q [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == {CNT_W{1'b0}});
  assign count_o   = count_q;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      else           wr_ptr_d = wr_ptr_q;
      if (do_pop_s)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      else           rd_ptr_d = rd_ptr_q;
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer, count and storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push_s && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the async instruction memory and
// buffers {pc, instr} for decode. Build option: FETCH_MISALIGN_TRAP_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                INSTR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [INSTR_W-1:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halted,
  output logic               misalign_err
);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  fetch_state_t                state_q, state_d;
  logic [ADDR_W-1:0]           pc_q, pc_d;
  logic                        push_s;
  logic                        pop_s;
  logic                        flush_s;
  logic                        can_push_s;
  logic                        full_s;
  logic                        empty_s;
  logic [$clog2(FIFO_DEPTH):0] count_s;
  entry_t                      head_s;
  entry_t                      wentry_s;

  assign imem_addr  = pc_q;
  assign pop_s      = !empty_s && out_ready;
  assign can_push_s = !full_s || pop_s;
  assign out_valid  = (count_s != '0);
  assign out_pc     = head_s.pc;
  assign out_instr  = head_s.instr;
  assign halted     = (state_q == HALTED);
  assign wentry_s   = '{pc: pc_q, instr: imem_instr};

`ifdef FETCH_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  assign misalign_err = mis_q;
`else
  logic unused_low_pc_s;
  assign misalign_err    = 1'b0;
  assign unused_low_pc_s = ^redirect_pc[1:0];
`endif

  // Redirect beats every state; otherwise fetch one word per free buffer slot.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push_s  = 1'b0;
    flush_s = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    if (redirect_valid) begin
      flush_s = 1'b1;
      pc_d    = {redirect_pc[ADDR_W-1:2], 2'b00};
      if (fetch_en) state_d = FETCH;
      else          state_d = IDLE;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) begin
        state_d = HALTED;
        mis_d   = 1'b1;
      end else begin
        mis_d   = mis_q;
      end
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (fetch_en) state_d = FETCH;
          else          state_d = IDLE;
        end
        FETCH: begin
          if (!fetch_en) begin
            state_d = IDLE;
          end else if (can_push_s) begin
            push_s = 1'b1;
            // A halt word is kept in the buffer but the PC stays on it.
            if (imem_instr == HALT_INSTR) state_d = HALTED;
            else                          pc_d    = pc_q + ADDR_W'(INSTR_BYTES);
          end else begin
            pc_d = pc_q;
          end
        end
        HALTED:  state_d = HALTED;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM and PC registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Sticky misaligned-redirect flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mis_q <= 1'b0;
    else       mis_q <= mis_d;
  end
`endif

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .flush_i (flush_s),
    .wdata_i (wentry_s),
    .rdata_o (head_s),
    .count_o (count_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the stimulus side predicts the instruction
// stream from the fetch rules, a negedge monitor pops and compares on handshake.
module tb_fetch_unit;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
  logic        misalign_err;
  logic [31:0] halt_addr;

  exp_t exp_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   halt_seen = 0;
  int   accepted  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] h);
    return (a == h) ? HALT : (a ^ 32'hA5A5_0000);
  endfunction

  assign imem_instr = mem_word(imem_addr, halt_addr);

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .misalign_err   (misalign_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected stream: sequential words from start, ending at (and including) a halt word.
  task automatic refill(input logic [31:0] start);
    logic [31:0] p;
    logic [31:0] w;
    exp_q.delete();
    p = start;
    for (int i = 0; i < 256; i++) begin
      w = mem_word(p, halt_addr);
      exp_q.push_back('{pc: p, instr: w});
      if (w == HALT) break;
      p = p + 32'd4;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    fetch_en       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt_addr      = 32'h1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    refill(32'h0);
  endtask

  task automatic redirect(input logic [31:0] pc, input logic [31:0] h);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    halt_addr      = h;
    @(posedge clk);
`ifdef FETCH_MISALIGN_TRAP_EN
    if (pc[1:0] != 2'b00) exp_q.delete();
    else                  refill({pc[31:2], 2'b00});
`else
    refill({pc[31:2], 2'b00});
`endif
    #1;
    redirect_valid = 1'b0;
    chk("redirect_flush_valid", {31'b0, out_valid}, 32'd0);
  endtask

  // Monitor: pops the scoreboard on every accepted handshake and checks head stability.
  initial begin
    exp_t        e;
    logic        hold_v;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    hold_v = 1'b0;
    hold_pc = 32'h0;
    hold_instr = 32'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          chk("hold_valid", {31'b0, out_valid}, 32'd1);
          chk("hold_pc", out_pc, hold_pc);
          chk("hold_instr", out_instr, hold_instr);
        end
        if (out_valid && out_ready) begin
          accepted++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_entry: got pc %h instr %h expected no entry", out_pc, out_instr);
          end else begin
            e = exp_q.pop_front();
            chk("sb_pc", out_pc, e.pc);
            chk("sb_instr", out_instr, e.instr);
            if (e.instr == HALT) halt_seen++;
          end
        end
        hold_v     = out_valid && !out_ready && !redirect_valid;
        hold_pc    = out_pc;
        hold_instr = out_instr;
      end
    end
  end

  initial begin
    int hs0;
    reset          = 1'b1;
    fetch_en       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt_addr      = 32'h1;
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_misalign", {31'b0, misalign_err}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);

    // Streaming at full throughput
    do_reset();
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    step();
    chk("latency_valid", {31'b0, out_valid}, 32'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      chk("stream_valid", {31'b0, out_valid}, 32'd1);
      chk("stream_pc", out_pc, 32'(k * 4));
      chk("stream_instr", out_instr, 32'(k * 4) ^ 32'hA5A5_0000);
      step();
    end

    // Backpressure fills the buffer and holds the PC
    do_reset();
    fetch_en = 1'b1;
    repeat (5) step();
    chk("full_addr", imem_addr, 32'h8);
    chk("full_pc", out_pc, 32'h0);
    step();
    chk("full_addr_hold", imem_addr, 32'h8);
    out_ready = 1'b1;
    chk("drain_pc0", out_pc, 32'h0);
    step();
    chk("drain_pc1", out_pc, 32'h4);
    step();
    chk("drain_pc2", out_pc, 32'h8);

    // Redirect with a full buffer
    do_reset();
    fetch_en = 1'b1;
    repeat (4) step();
    redirect(32'h40, 32'h1);
    out_ready = 1'b1;
    step();
    chk("redir_valid", {31'b0, out_valid}, 32'd1);
    chk("redir_pc0", out_pc, 32'h40);
    step();
    chk("redir_pc1", out_pc, 32'h44);

    // Halt word at 0x10, then resume by redirect
    hs0 = halt_seen;
    redirect(32'h0, 32'h10);
    repeat (10) step();
    chk("halt_flag", {31'b0, halted}, 32'd1);
    chk("halt_no_valid", {31'b0, out_valid}, 32'd0);
    chk("halt_addr_hold", imem_addr, 32'h10);
    chk("halt_seen", 32'(halt_seen), 32'(hs0 + 1));
    redirect(32'h0, 32'h1);
    chk("halt_clear", {31'b0, halted}, 32'd0);
    step();
    chk("resume_pc", out_pc, 32'h0);

    // Asynchronous reset between edges
    repeat (3) step();
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("async_rst_addr", imem_addr, 32'h0);
    exp_q.delete();
    fetch_en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    refill(32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("post_rst_idle", {31'b0, out_valid}, 32'd0);
    end
    fetch_en = 1'b1;
    step();
    step();
    chk("restart_pc", out_pc, 32'h0);

    // Misaligned redirect
    redirect(32'h42, 32'h1);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_err", {31'b0, misalign_err}, 32'd1);
    chk("mis_halted", {31'b0, halted}, 32'd1);
    chk("mis_addr", imem_addr, 32'h40);
    step();
    chk("mis_no_valid", {31'b0, out_valid}, 32'd0);
`else
    step();
    chk("mis_pc", out_pc, 32'h40);
    chk("mis_err", {31'b0, misalign_err}, 32'd0);
`endif

    // PC wrap at the top of the address space
    redirect(32'hFFFF_FFF8, 32'h1);
    step();
    chk("wrap_pc0", out_pc, 32'hFFFF_FFF8);
    step();
    chk("wrap_pc1", out_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc2", out_pc, 32'h0000_0000);
    step();
    chk("wrap_pc3", out_pc, 32'h0000_0004);

    // Randomized traffic
    accepted = 0;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk);
      if (redirect_valid) refill({redirect_pc[31:2], 2'b00});
      #1;
      redirect_valid = ($urandom_range(0, 19) == 0);
      if (redirect_valid) begin
        redirect_pc = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 1) == 1) halt_addr = redirect_pc + 32'($urandom_range(0, 15) * 4);
        else                           halt_addr = 32'h1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      fetch_en  = ($urandom_range(0, 9) != 0);
    end
    @(posedge clk);
    if (redirect_valid) refill({redirect_pc[31:2], 2'b00});
    #1;
    redirect_valid = 1'b0;
    fetch_en       = 1'b0;
    out_ready      = 1'b1;
    repeat (4) step();
    chk("random_progress", {31'b0, (accepted > 50)}, 32'd1);
    chk("drained", {31'b0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
